// File: rtl/led_fader_pkg.sv
// Shared constants and helpers for the LED fader and the Wishbone LED register.
package led_fader_pkg;

  localparam int DEF_NUM_LEDS = 8;
  localparam int DEF_PWM_BITS = 8;

  typedef enum logic [1:0] {
    FADE_HOLD,
    FADE_UP,
    FADE_DOWN
  } fade_dir_e;

  // One extra bit holds the carry/borrow so saturation is detected without wrap.
  function automatic int sat_width(input int pwm_bits);
    return pwm_bits + 1;
  endfunction

endpackage

// File: rtl/led_fader_if.sv
// LED target/bypass inputs and PWM/busy outputs between the LED register and the fader.
interface led_fader_if import led_fader_pkg::*; #(
  parameter int NUM_LEDS = DEF_NUM_LEDS
);

  logic [NUM_LEDS-1:0] i_leds;
  logic                i_bypass;
  logic [NUM_LEDS-1:0] o_pwm;
  logic                o_busy;

  modport master (
    output i_leds,
    output i_bypass,
    input  o_pwm,
    input  o_busy
  );

  modport slave (
    input  i_leds,
    input  i_bypass,
    output o_pwm,
    output o_busy
  );

endinterface

// File: rtl/led_fader_chan.sv
// One LED channel: duty register with saturating fade step and registered PWM comparator.
module led_fader_chan import led_fader_pkg::*; #(
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int STEP     = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_target_on,
  input  logic                i_bypass,
  input  logic                i_tick,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_pwm,
  output logic                o_mismatch
);

  localparam int            SW     = sat_width(PWM_BITS);
  localparam logic [SW-1:0] MAX_W  = {1'b0, {PWM_BITS{1'b1}}};
  localparam logic [SW-1:0] STEP_W = SW'(STEP);

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;
  logic [PWM_BITS-1:0] target;
  logic [SW-1:0]       sum;
  logic [SW-1:0]       diff;
  fade_dir_e           dir;

  always_comb begin
    target = i_target_on ? {PWM_BITS{1'b1}} : '0;
    sum    = {1'b0, duty_q} + STEP_W;
    diff   = {1'b0, duty_q} - STEP_W;

    dir = FADE_HOLD;
    if (duty_q < target) begin
      dir = FADE_UP;
    end else if (duty_q > target) begin
      dir = FADE_DOWN;
    end

    duty_d = duty_q;
    if (i_bypass) begin
      duty_d = target;
    end else if (i_tick) begin
      // The MSB of diff is the borrow: set means the step went below zero.
      case (dir)
        FADE_UP:   duty_d = (sum > MAX_W) ? {PWM_BITS{1'b1}} : sum[PWM_BITS-1:0];
        FADE_DOWN: duty_d = diff[SW-1] ? '0 : diff[PWM_BITS-1:0];
        default:   duty_d = duty_q;
      endcase
    end

    pwm_d      = (duty_q == {PWM_BITS{1'b1}}) || (i_pwm_cnt < duty_q);
    o_mismatch = (duty_q != target);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign o_pwm = pwm_q;

endmodule

// File: rtl/led_fader.sv
// Multi-channel LED fader: shared prescaler and PWM counter driving one channel per LED.
module led_fader import led_fader_pkg::*; #(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int PRESCALE = 1024,
  parameter int STEP     = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  led_fader_if.slave fader
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     pre_q, pre_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                busy_q, busy_d;
  logic                tick;
  logic [NUM_LEDS-1:0] mismatch;
  logic [NUM_LEDS-1:0] pwm_vec;

  always_comb begin
    tick      = (pre_q == PS_LAST);
    pre_d     = tick ? '0 : pre_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    busy_d    = |mismatch;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pre_q     <= '0;
      pwm_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      pwm_cnt_q <= pwm_cnt_d;
      busy_q    <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_LEDS; k++) begin : g_chan
    led_fader_chan #(
      .PWM_BITS (PWM_BITS),
      .STEP     (STEP)
    ) u_chan (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_target_on (fader.i_leds[k]),
      .i_bypass    (fader.i_bypass),
      .i_tick      (tick),
      .i_pwm_cnt   (pwm_cnt_q),
      .o_pwm       (pwm_vec[k]),
      .o_mismatch  (mismatch[k])
    );
  end

  assign fader.o_pwm  = pwm_vec;
  assign fader.o_busy = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: expected duty values queued at stimulus time, popped at each tick.
module tb_led_fader;
  import led_fader_pkg::*;

  localparam int NL      = DEF_NUM_LEDS;
  localparam int PB      = 8;
  localparam int PS      = 4;
  localparam int ST      = 64;
  localparam int PS_SLOW = 512;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [PB-1:0] exp_q[$];

  always #5 clk = ~clk;

  led_fader_if #(.NUM_LEDS(NL)) fif ();
  led_fader_if #(.NUM_LEDS(NL)) sif ();

  led_fader #(
    .NUM_LEDS (NL),
    .PWM_BITS (PB),
    .PRESCALE (PS),
    .STEP     (ST)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .fader   (fif)
  );

  // Slow twin keeps a duty level steady long enough to measure whole PWM periods.
  led_fader #(
    .NUM_LEDS (NL),
    .PWM_BITS (PB),
    .PRESCALE (PS_SLOW),
    .STEP     (ST)
  ) dut_slow (
    .i_clk   (clk),
    .i_reset (rst),
    .fader   (sif)
  );

  logic [PB-1:0] duty_obs [NL];
  logic [PB-1:0] slow_duty0;
  for (genvar k = 0; k < NL; k++) begin : g_obs
    assign duty_obs[k] = dut.g_chan[k].u_chan.duty_q;
  end
  assign slow_duty0 = dut_slow.g_chan[0].u_chan.duty_q;

  task automatic do_reset(input logic [NL-1:0] leds, input logic byp);
    rst = 1'b1;
    @(posedge clk); #1;
    rst          = 1'b0;
    fif.i_leds   = leds;
    fif.i_bypass = byp;
    sif.i_leds   = '0;
    sif.i_bypass = 1'b0;
  endtask

  task automatic wait_change(input int k, output int n, output logic [PB-1:0] v, output bit to);
    logic [PB-1:0] prev;
    prev = duty_obs[k];
    n    = 0;
    v    = prev;
    to   = 1'b1;
    for (int i = 0; i < 3 * PS; i++) begin
      @(posedge clk); #1;
      n++;
      if (duty_obs[k] !== prev) begin
        v  = duty_obs[k];
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst          = 1'b1;
    fif.i_leds   = '1;
    fif.i_bypass = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bad = 0;
    for (int k = 0; k < NL; k++) if (duty_obs[k] !== '0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL reset_duty: %0d channels nonzero, required 0", bad);
    end
    checks++;
    if (fif.o_pwm !== '0) begin
      errors++;
      $display("[TB] FAIL reset_pwm: got %h required 00", fif.o_pwm);
    end
    checks++;
    if (fif.o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b required 0", fif.o_busy);
    end
  endtask

  task automatic test_idle();
    int bad;
    do_reset('0, 1'b0);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (fif.o_pwm !== '0 || fif.o_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL idle_outputs: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_fade_up();
    int n; logic [PB-1:0] v; bit to; logic [PB-1:0] e; int bad;
    do_reset(8'h01, 1'b0);
    exp_q.push_back(8'd64);
    exp_q.push_back(8'd128);
    exp_q.push_back(8'd192);
    exp_q.push_back(8'd255);
    for (int i = 0; i < 4; i++) begin
      wait_change(0, n, v, to);
      e = exp_q.pop_front();
      checks++;
      if (to || v !== e) begin
        errors++;
        $display("[TB] FAIL fade_up_step%0d: duty %0d required %0d (timeout=%0b)", i, v, e, to);
      end
      checks++;
      if (n != PS) begin
        errors++;
        $display("[TB] FAIL fade_up_period%0d: %0d clocks required %0d", i, n, PS);
      end
      checks++;
      if (fif.o_busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL fade_up_busy%0d: got %b required 1", i, fif.o_busy);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (fif.o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fade_up_busy_fall: got %b required 0", fif.o_busy);
    end
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (fif.o_pwm !== 8'h01 || fif.o_busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL fade_up_full_on: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_duty_half();
    int ones; int cyc; logic [PB-1:0] e;
    do_reset('0, 1'b0);
    sif.i_leds = 8'h01;
    cyc = 0;
    while (slow_duty0 !== 8'd128 && cyc < 1500) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (slow_duty0 !== 8'd128) begin
      errors++;
      $display("[TB] FAIL half_reach: duty %0d required 128", slow_duty0);
    end
    checks++;
    if (sif.o_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL half_busy: got %b required 1", sif.o_busy);
    end
    exp_q.push_back(8'd128);
    repeat (2) @(posedge clk);
    #1;
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      if (sif.o_pwm[0] === 1'b1) ones++;
      @(posedge clk); #1;
    end
    e = exp_q.pop_front();
    checks++;
    if (ones != int'(e)) begin
      errors++;
      $display("[TB] FAIL half_high_count: %0d of 256 high, required %0d", ones, e);
    end
    sif.i_leds = '0;
  endtask

  task automatic test_reverse();
    int n; logic [PB-1:0] v; bit to; logic [PB-1:0] e; int bad;
    do_reset(8'h01, 1'b0);
    exp_q.push_back(8'd64);
    exp_q.push_back(8'd128);
    exp_q.push_back(8'd192);
    for (int i = 0; i < 3; i++) begin
      wait_change(0, n, v, to);
      e = exp_q.pop_front();
      checks++;
      if (to || v !== e) begin
        errors++;
        $display("[TB] FAIL reverse_up%0d: duty %0d required %0d (timeout=%0b)", i, v, e, to);
      end
    end
    fif.i_leds = 8'h00;
    exp_q.push_back(8'd128);
    exp_q.push_back(8'd64);
    exp_q.push_back(8'd0);
    for (int i = 0; i < 3; i++) begin
      wait_change(0, n, v, to);
      e = exp_q.pop_front();
      checks++;
      if (to || v !== e || n != PS) begin
        errors++;
        $display("[TB] FAIL reverse_down%0d: duty %0d after %0d clocks, required %0d after %0d", i, v, n, e, PS);
      end
    end
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (fif.o_pwm !== 8'h00 || fif.o_busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL reverse_off: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_bypass();
    logic [NL-1:0] pat; logic [PB-1:0] e; int bad;
    do_reset('0, 1'b0);
    pat          = 8'hA5;
    fif.i_bypass = 1'b1;
    fif.i_leds   = pat;
    for (int k = 0; k < NL; k++) exp_q.push_back(pat[k] ? 8'd255 : 8'd0);
    @(posedge clk); #1;
    bad = 0;
    for (int k = 0; k < NL; k++) begin
      e = exp_q.pop_front();
      if (duty_obs[k] !== e) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL bypass_load: %0d channels wrong, required 0", bad);
    end
    checks++;
    if (fif.o_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bypass_busy_first: got %b required 1", fif.o_busy);
    end
    @(posedge clk); #1;
    checks++;
    if (fif.o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bypass_busy: got %b required 0", fif.o_busy);
    end
    checks++;
    if (fif.o_pwm !== pat) begin
      errors++;
      $display("[TB] FAIL bypass_pwm: got %h required %h", fif.o_pwm, pat);
    end
    pat        = 8'h5A;
    fif.i_leds = pat;
    for (int k = 0; k < NL; k++) exp_q.push_back(pat[k] ? 8'd255 : 8'd0);
    @(posedge clk); #1;
    bad = 0;
    for (int k = 0; k < NL; k++) begin
      e = exp_q.pop_front();
      if (duty_obs[k] !== e) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL bypass_reload: %0d channels wrong, required 0", bad);
    end
    fif.i_bypass = 1'b0;
    fif.i_leds   = '0;
  endtask

  task automatic test_reset_mid_fade();
    int n; logic [PB-1:0] v; bit to; logic [PB-1:0] e; int bad;
    do_reset(8'h08, 1'b0);
    exp_q.push_back(8'd64);
    exp_q.push_back(8'd128);
    for (int i = 0; i < 2; i++) begin
      wait_change(3, n, v, to);
      e = exp_q.pop_front();
      checks++;
      if (to || v !== e) begin
        errors++;
        $display("[TB] FAIL midreset_up%0d: duty %0d required %0d (timeout=%0b)", i, v, e, to);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < NL; k++) if (duty_obs[k] !== '0) bad++;
    checks++;
    if (bad != 0 || fif.o_pwm !== '0 || fif.o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: pwm %h busy %b nonzero duties %0d, required 00 0 0", fif.o_pwm, fif.o_busy, bad);
    end
    exp_q.push_back(8'd64);
    wait_change(3, n, v, to);
    e = exp_q.pop_front();
    checks++;
    if (to || v !== e || n != PS) begin
      errors++;
      $display("[TB] FAIL midreset_restart: duty %0d after %0d clocks, required %0d after %0d", v, n, e, PS);
    end
  endtask

  initial begin
    rst          = 1'b1;
    fif.i_leds   = '0;
    fif.i_bypass = 1'b0;
    sif.i_leds   = '0;
    sif.i_bypass = 1'b0;
    test_reset();
    test_idle();
    test_fade_up();
    test_duty_half();
    test_reverse();
    test_bypass();
    test_reset_mid_fade();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter NUM_LEDS, default 8: number of LED channels.
REQ-002 Parameter PWM_BITS, default 8: duty and PWM counter width; MAX = 2^PWM_BITS-1.
REQ-003 Parameter PRESCALE, default 1024: clocks per fade tick, >=2.
REQ-004 Parameter STEP, default 1: duty increment/decrement per fade tick, 1..MAX.
REQ-005 i_clk  in  1: clock, all logic on rising edge.
REQ-006 i_reset  in  1: reset, synchronous, active-high.
REQ-007 i_leds  in  NUM_LEDS: target on/off per LED, driven by the Wishbone LED register output, already synchronous to i_clk.
REQ-008 i_bypass  in  1: 1 = no fading, duty jumps to target.
REQ-009 o_pwm  out  NUM_LEDS: registered PWM drive per LED, to pads.
REQ-010 o_busy  out  1: registered; 1 while any duty differs from its target.

Function
REQ-011 PWM counter pwm_cnt, PWM_BITS wide, SHALL increment every clock and wrap MAX->0.
REQ-012 Prescaler SHALL count 0..PRESCALE-1 and wrap; tick SHALL be asserted for the single cycle the count equals PRESCALE-1.
REQ-013 Per-LED duty[k], PWM_BITS wide; target[k] = MAX if i_leds[k] else 0.
REQ-014 On tick with i_bypass=0: duty[k] < target -> duty[k] = min(duty[k]+STEP, MAX); duty[k] > target -> duty[k] = max(duty[k]-STEP, 0); otherwise unchanged.
REQ-015 Saturation SHALL be computed at PWM_BITS+1 width; duty SHALL never wrap.
REQ-016 Without a tick and with i_bypass=0, duty SHALL hold.
REQ-017 i_bypass=1 SHALL load duty[k] = target[k] every clock, regardless of tick.
REQ-018 i_leds toggling mid-fade SHALL reverse direction from the current duty on the next tick; no restart from 0 or MAX.
REQ-019 o_pwm[k] next value = 1 if duty[k]==MAX, else (pwm_cnt < duty[k]); duty 0 -> constant 0, duty MAX -> constant 1.
REQ-020 o_pwm latency: one clock after the duty/pwm_cnt values it compares.
REQ-021 o_busy next value = OR over k of (duty[k] != target[k]), using current duty and current i_leds.
REQ-022 No glitch: o_pwm and o_busy SHALL be flop outputs only.

Reset
REQ-023 i_reset=1 SHALL clear pwm_cnt, prescaler, all duty, o_pwm and o_busy to 0 on the next edge.
REQ-024 Reset SHALL take priority over tick and i_bypass; after reset deassertion the first tick SHALL occur PRESCALE clocks later.
REQ-025 Reset mid-fade SHALL abandon the fade; fading restarts from duty 0.

Structure
REQ-026 Shared package SHALL hold default constants NUM_LEDS, PWM_BITS, and the saturating add/sub width rule, shared with the Wishbone LED register.
REQ-027 One sub-module led_fader_chan (one duty register, saturating step, comparator, o_pwm flop) SHALL be instantiated NUM_LEDS times via generate; prescaler, pwm_cnt and busy OR stay in the top.

Verification (PRESCALE=4, STEP=64, PWM_BITS=8)
REQ-028 Reset, then i_leds=0x00 for 1000 clocks -> o_pwm=0x00 constant, o_busy=0.
REQ-029 i_leds 0x00->0x01 -> duty[0] = 64,128,192,255 on 4 successive ticks (saturation at 255); o_busy falls the clock after duty[0] reaches 255; o_pwm[0] then constant 1.
REQ-030 duty[0]=128 with i_leds[0]=1 held -> o_pwm[0] high exactly 128 of every 256 clocks.
REQ-031 i_leds[0] 1->0 when duty[0]=192 -> next ticks 128,64,0; o_pwm[0] constant 0 afterwards.
REQ-032 i_bypass=1, i_leds=0xA5 -> one clock later duty=MAX on LEDs 0,2,5,7 and 0 elsewhere; o_busy=0 one clock after that.
REQ-033 i_reset asserted at duty[3]=128 -> all outputs 0 next clock; first tick after release PRESCALE clocks later, duty[3]=64 if i_leds[3]=1.
